// File: rtl/pool2_pkg.sv
// Shared definitions for the conv2 -> pool2 -> flatten/dense chain.
// Holds the pooling FSM state type and the feature-map geometry constants.
package pool2_pkg;

    localparam int CONV2_CHANNELS = 32;
    localparam int CONV2_DIM      = 14;
    localparam int POOL2_DIM      = 7;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        WAIT_START_LOW
    } pool2_state_t;

endpackage

// File: rtl/pool_max_unit.sv
// Running-maximum register for one 2x2 window.
// Load takes the first element unconditionally; later elements replace it only when strictly greater.
module pool_max_unit (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               en,
    input  logic signed [31:0] value,
    output logic signed [31:0] max
);

    logic signed [31:0] r_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_max <= '0;
        end else if (en && (load || (value > r_max))) begin
            r_max <= value;
        end
    end

    assign max = r_max;

endmodule

// File: rtl/pool2.sv
// 2x2 stride-2 max pooling over CHANNELS feature maps, one window element per cycle.
// Each output costs four READ cycles plus one WRITE cycle; done is held until the next accepted start.
module pool2
    import pool2_pkg::*;
#(
    parameter int CHANNELS = CONV2_CHANNELS,
    parameter int IN_DIM   = CONV2_DIM
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               done,
    input  logic signed [31:0] conv2_maps [CHANNELS][IN_DIM][IN_DIM],
    output logic signed [31:0] pool2_maps [CHANNELS][IN_DIM/2][IN_DIM/2]
);

    localparam int OUT_DIM = IN_DIM / 2;
    localparam int FW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int OW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [FW-1:0] LAST_F = FW'(CHANNELS - 1);
    localparam logic [OW-1:0] LAST_O = OW'(OUT_DIM - 1);

    pool2_state_t       r_state;
    logic               r_done;
    logic [FW-1:0]      r_f;
    logic [OW-1:0]      r_oi;
    logic [OW-1:0]      r_oj;
    logic [1:0]         r_k;

    logic [OW:0]        w_row;
    logic [OW:0]        w_col;
    logic signed [31:0] w_value;
    logic signed [31:0] w_max;
    logic               w_last;

    // k[1] picks the lower window row and k[0] the right column, giving the required element order.
    assign w_row   = {r_oi, r_k[1]};
    assign w_col   = {r_oj, r_k[0]};
    assign w_value = conv2_maps[r_f][w_row][w_col];
    assign w_last  = (r_f == LAST_F) && (r_oi == LAST_O) && (r_oj == LAST_O);

    pool_max_unit u_max (
        .clk   (clk),
        .reset (reset),
        .load  ((r_state == READ) && (r_k == 2'd0)),
        .en    (r_state == READ),
        .value (w_value),
        .max   (w_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_f     <= '0;
            r_oi    <= '0;
            r_oj    <= '0;
            r_k     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_done  <= 1'b0;
                        r_f     <= '0;
                        r_oi    <= '0;
                        r_oj    <= '0;
                        r_k     <= '0;
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_k <= r_k + 2'd1;
                    if (r_k == 2'd3) begin
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    r_k <= '0;
                    if (r_oj == LAST_O) begin
                        r_oj <= '0;
                        if (r_oi == LAST_O) begin
                            r_oi <= '0;
                            r_f  <= r_f + FW'(1);
                        end else begin
                            r_oi <= r_oi + OW'(1);
                        end
                    end else begin
                        r_oj <= r_oj + OW'(1);
                    end
                    r_state <= w_last ? DONE : READ;
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= WAIT_START_LOW;
                end
                WAIT_START_LOW: begin
                    if (!start) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i < OUT_DIM; i++) begin
                    for (int j = 0; j < OUT_DIM; j++) begin
                        pool2_maps[c][i][j] <= '0;
                    end
                end
            end
        end else if (r_state == WRITE) begin
            pool2_maps[r_f][r_oi][r_oj] <= w_max;
        end
    end

    assign done = r_done;

endmodule

// File: tb/tb_pool2.sv
// Scoreboard bench for pool2: stimulus pushes expected maps and done timing, a monitor checks them when done rises.
// Covers ramp data, negatives, ties, extremes, mid-pass reset and the start/done handshake.
module tb_pool2;

    localparam int CH         = 32;
    localparam int ID         = 14;
    localparam int OD         = 7;
    localparam int PASS_EDGES = 7841;
    localparam int TIMEOUT    = 9000;

    typedef struct {
        int                 f;
        int                 i;
        int                 j;
        logic signed [31:0] v;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               done;
    logic signed [31:0] conv2_maps [CH][ID][ID];
    logic signed [31:0] pool2_maps [CH][OD][OD];
    logic signed [31:0] expMap     [CH][OD][OD];

    exp_t dataQ[$];
    int   startQ[$];
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;
    logic prevDone = 1'b0;

    pool2 #(.CHANNELS(CH), .IN_DIM(ID)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .conv2_maps (conv2_maps),
        .pool2_maps (pool2_maps)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     name, actual, actual, expected, expected);
        end
    endtask

    function automatic int countNonzero();
        int n = 0;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < OD; i++)
                for (int j = 0; j < OD; j++)
                    if (pool2_maps[c][i][j] !== 32'sd0) n++;
        return n;
    endfunction

    function automatic int countDiffFromExpected();
        int n = 0;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < OD; i++)
                for (int j = 0; j < OD; j++)
                    if (pool2_maps[c][i][j] !== expMap[c][i][j]) n++;
        return n;
    endfunction

    task automatic setRamp();
        for (int c = 0; c < CH; c++)
            for (int y = 0; y < ID; y++)
                for (int x = 0; x < ID; x++)
                    conv2_maps[c][y][x] = c * 1000 + y * 14 + x;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < OD; i++)
                for (int j = 0; j < OD; j++)
                    expMap[c][i][j] = c * 1000 + (2 * i + 1) * 14 + 2 * j + 1;
    endtask

    task automatic setWindow(input int f, input int oi, input int oj,
                             input logic signed [31:0] a, input logic signed [31:0] b,
                             input logic signed [31:0] c, input logic signed [31:0] d,
                             input logic signed [31:0] expected);
        conv2_maps[f][2*oi][2*oj]       = a;
        conv2_maps[f][2*oi][2*oj+1]     = b;
        conv2_maps[f][2*oi+1][2*oj]     = c;
        conv2_maps[f][2*oi+1][2*oj+1]   = d;
        expMap[f][oi][oj]               = expected;
    endtask

    task automatic setDirected();
        for (int c = 0; c < CH; c++)
            for (int y = 0; y < ID; y++)
                for (int x = 0; x < ID; x++)
                    conv2_maps[c][y][x] = -32'sd1;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < OD; i++)
                for (int j = 0; j < OD; j++)
                    expMap[c][i][j] = -32'sd1;
        setWindow(0, 0, 0, -32'sd5, -32'sd3, -32'sd9, -32'sd7, -32'sd3);
        setWindow(0, 0, 1, 32'sd7, 32'sd7, 32'sd2, 32'sd7, 32'sd7);
        setWindow(0, 0, 2, 32'sd100, 32'sd1, 32'sd2, 32'sd3, 32'sd100);
        setWindow(0, 0, 3, 32'sd1, 32'sd100, 32'sd2, 32'sd3, 32'sd100);
        setWindow(0, 0, 4, 32'sd1, 32'sd2, 32'sd100, 32'sd3, 32'sd100);
        setWindow(0, 0, 5, 32'sd1, 32'sd2, 32'sd3, 32'sd100, 32'sd100);
        setWindow(1, 0, 0, 32'sh80000000, 32'sh7FFFFFFF, -32'sd1, 32'sd0, 32'sh7FFFFFFF);
        setWindow(1, 0, 1, 32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000,
                  32'sh80000000);
        setWindow(31, 6, 6, 32'sd3, 32'sd9, 32'sd4, 32'sd1, 32'sd9);
    endtask

    task automatic pushExpected();
        exp_t e;
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < OD; i++)
                for (int j = 0; j < OD; j++) begin
                    e.f = c;
                    e.i = i;
                    e.j = j;
                    e.v = expMap[c][i][j];
                    dataQ.push_back(e);
                end
    endtask

    // Raises start at a negedge so the next rising edge is the acceptance edge.
    task automatic applyStimulus(input bit holdStart, input bit expectDone, output int startAt);
        @(negedge clk);
        start   = 1'b1;
        startAt = cycle + 1;
        if (expectDone) begin
            pushExpected();
            startQ.push_back(startAt);
        end
        @(negedge clk);
        checkOutput("doneClearedOnAccept", {31'd0, done}, 32'sd0);
        if (!holdStart) start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (done !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, done}, 32'sd1);
        @(negedge clk);
    endtask

    initial begin : monitor
        int   s;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && prevDone !== 1'b1) begin
                if (startQ.size() == 0) begin
                    checkOutput("unexpectedDone", {31'd0, done}, 32'sd0);
                end else begin
                    s = startQ.pop_front();
                    checkOutput("doneLatency", cycle - s, PASS_EDGES);
                    for (int n = 0; n < CH * OD * OD && dataQ.size() > 0; n++) begin
                        e = dataQ.pop_front();
                        checkOutput($sformatf("pool2_maps[%0d][%0d][%0d]", e.f, e.i, e.j),
                                    pool2_maps[e.f][e.i][e.j], e.v);
                    end
                end
            end
            prevDone = done;
        end
    end

    initial begin : stimulus
        int s;
        int heldLow;

        reset = 1'b1;
        start = 1'b0;
        setRamp();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("resetDone", {31'd0, done}, 32'sd0);
        checkOutput("resetMapsNonzero", countNonzero(), 32'sd0);
        repeat (10) @(negedge clk);
        checkOutput("idleNoStartDone", {31'd0, done}, 32'sd0);

        $display("[TB] ramp pass");
        applyStimulus(1'b0, 1'b1, s);
        waitDone("rampDoneTimeout");

        $display("[TB] negatives / ties / extremes pass");
        setDirected();
        applyStimulus(1'b0, 1'b1, s);
        repeat (5) @(negedge clk);
        checkOutput("firstWriteTiming", pool2_maps[0][0][0], -32'sd3);
        checkOutput("unwrittenRetained", pool2_maps[0][0][1], 32'sd17);
        checkOutput("lastRetained", pool2_maps[31][6][6], 32'sd31195);
        waitDone("directedDoneTimeout");

        $display("[TB] reset mid-pass");
        setRamp();
        applyStimulus(1'b0, 1'b0, s);
        while (cycle < s + 2999) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midResetDone", {31'd0, done}, 32'sd0);
        checkOutput("midResetMapsNonzero", countNonzero(), 32'sd0);
        repeat (20) @(negedge clk);
        checkOutput("postResetIdleDone", {31'd0, done}, 32'sd0);
        checkOutput("postResetIdleMaps", countNonzero(), 32'sd0);
        applyStimulus(1'b0, 1'b1, s);
        waitDone("restartDoneTimeout");

        $display("[TB] handshake: start held high");
        setDirected();
        applyStimulus(1'b1, 1'b1, s);
        waitDone("heldDoneTimeout");
        for (int c = 0; c < CH; c++)
            for (int y = 0; y < ID; y++)
                for (int x = 0; x < ID; x++)
                    conv2_maps[c][y][x] = 32'sd0;
        heldLow = 0;
        repeat (100) begin
            @(negedge clk);
            if (done !== 1'b1) heldLow++;
        end
        checkOutput("doneHeldWithStartHigh", heldLow, 32'sd0);
        checkOutput("noSecondPassDiffs", countDiffFromExpected(), 32'sd0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("doneHeldInIdle", {31'd0, done}, 32'sd1);

        $display("[TB] handshake: re-pulse start");
        setDirected();
        applyStimulus(1'b0, 1'b1, s);
        waitDone("secondDoneTimeout");

        repeat (2) @(negedge clk);
        checkOutput("scoreboardDataDrained", dataQ.size(), 32'sd0);
        checkOutput("scoreboardStartDrained", startQ.size(), 32'sd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pool2.md
POOL2 -- requirements
Module: pool2

Interface
REQ-001 Parameter CHANNELS, default 32, number of input/output feature maps.
REQ-002 Parameter IN_DIM, default 14, input map height/width; SHALL be even.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level request to begin one pooling pass.
REQ-006 done  output  1  high when a full pass has completed; held until next accepted start.
REQ-007 conv2_maps  input  signed 32 x [CHANNELS][IN_DIM][IN_DIM]  conv2 feature maps, stable from start acceptance until done.
REQ-008 pool2_maps  output  signed 32 x [CHANNELS][IN_DIM/2][IN_DIM/2]  registered 2x2 stride-2 max-pooled maps.

Function
REQ-009 FSM states SHALL be IDLE, READ, WRITE, DONE, WAIT_START_LOW.
REQ-010 IDLE: when start=1, clear done, f, oi, oj, k to 0 and go to READ; else stay.
REQ-011 READ: one window element per cycle, k=0..3, order (2oi,2oj), (2oi,2oj+1), (2oi+1,2oj), (2oi+1,2oj+1) of map f.
REQ-012 k=0 SHALL load the running max; k=1..3 SHALL replace it only if element is strictly greater (signed 32-bit compare).
REQ-013 After k=3, go to WRITE; WRITE stores running max to pool2_maps[f][oi][oj].
REQ-014 Scan order: oj innermost, then oi, then f; WRITE advances indices with wrap (oj 6->0 increments oi; oi 6->0 increments f).
REQ-015 WRITE of last output (f=CHANNELS-1, oi=oj=IN_DIM/2-1) SHALL go to DONE; otherwise to READ with k=0.
REQ-016 Each output SHALL take exactly 5 cycles (4 READ + 1 WRITE); no idle cycles between outputs.
REQ-017 Default latency: start sampled in IDLE at cycle 0; output p written at edge ending cycle 5p+5; last WRITE cycle 7840; DONE cycle 7841; done=1 from cycle 7842.
REQ-018 DONE: set done=1, go to WAIT_START_LOW; WAIT_START_LOW: go to IDLE only when start=0.
REQ-019 start asserted in any state other than IDLE SHALL be ignored; no restart of an active pass.
REQ-020 start held high continuously SHALL produce exactly one pass.
REQ-021 Outputs not yet written in the current pass SHALL retain prior values; no arithmetic beyond comparison, no width change, no saturation.

Reset
REQ-022 reset=1 at any rising edge SHALL force state IDLE, done=0, f=oi=oj=k=0, running max=0, all pool2_maps entries=0, overriding every other action including a mid-pass WRITE.
REQ-023 After reset release, no pass begins until start=1 is sampled in IDLE.

Structure
REQ-024 Shared package SHALL hold the state enum and constants CONV2_CHANNELS=32, CONV2_DIM=14, POOL2_DIM=7, shared with conv2 and the downstream flatten/dense stage.
REQ-025 One sub-module, pool_max_unit, SHALL hold the running-max register and the signed load/compare (inputs: clk, reset, load, en, value; output: max).
REQ-026 Window element addressing SHALL be combinational from f, oi, oj, k; no copy of conv2_maps is buffered.

Verification
REQ-027 Ramp: conv2_maps[c][y][x]=c*1000+y*14+x, pulse start -> pool2_maps[c][i][j]=c*1000+(2i+1)*14+2j+1 for all entries; done at cycle 7842.
REQ-028 Negatives: window of map 0 at (0,0) = {-5,-3,-9,-7}, all else -1 -> pool2_maps[0][0][0]=-3, others -1.
REQ-029 Ties and position: window {7,7,2,7} -> 7; max in each of the four positions in turn -> that value every time.
REQ-030 Reset mid-pass: assert reset at cycle 3000 for one cycle -> done=0, all outputs 0, state IDLE; new start yields full correct result with done at 7842 cycles after that start.
REQ-031 Handshake: start held high through and past done -> one pass only, done stays 1; drop start then re-pulse -> done falls the cycle after acceptance and a second pass completes identically.
REQ-032 Extremes: inputs 32'sh7FFFFFFF and 32'sh80000000 in one window -> 32'sh7FFFFFFF; all-0x80000000 window -> 32'sh80000000.
